// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one fixed-latency SRAM between IF fetches and MEM
//                    loads/stores, and generates the pipeline freeze controls.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int MEM_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        branch_flush,
   input  logic        mem_rd_en,
   input  logic        mem_wr_en,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] if_instr,
   output logic        if_ready,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        freeze_if,
   output logic        freeze_pipe,
   output logic        sram_en,
   output logic        sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [3:0] C_CNT_INIT = 4'(MEM_LAT - 1);

   logic [1:0]  state_q,     state_d;
   logic [3:0]  cnt_q,       cnt_d;
   logic        discard_q,   discard_d;
   logic [31:0] addr_q,      addr_d;
   logic        we_q,        we_d;
   logic [31:0] wdata_q,     wdata_d;
   logic [31:0] if_instr_q,  if_instr_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;
   logic        if_ready_q,  if_ready_d;
   logic        mem_ready_q, mem_ready_d;

   logic        data_req;
   logic        fetch_dead;

   assign data_req   = mem_rd_en | mem_wr_en;
   assign fetch_dead = discard_q | branch_flush;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         discard_q   <= 1'b0;
         addr_q      <= 32'd0;
         we_q        <= 1'b0;
         wdata_q     <= 32'd0;
         if_instr_q  <= 32'd0;
         mem_rdata_q <= 32'd0;
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         discard_q   <= discard_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         if_instr_q  <= if_instr_d;
         mem_rdata_q <= mem_rdata_d;
         if_ready_q  <= if_ready_d;
         mem_ready_q <= mem_ready_d;
      end
   end

   // Next-state logic; data wins in IDLE because the MEM stage is older
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (data_req)    state_d = S_DATA;
            else if (if_req) state_d = S_FETCH;
         end
         S_FETCH, S_DATA: begin
            if (cnt_q == 4'd0) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      discard_d   = discard_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      if_instr_d  = if_instr_q;
      mem_rdata_d = mem_rdata_q;
      if_ready_d  = 1'b0;
      mem_ready_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (data_req) begin
               addr_d  = mem_addr;
               we_d    = mem_wr_en;
               wdata_d = mem_wdata;
               cnt_d   = C_CNT_INIT;
            end else if (if_req) begin
               addr_d  = if_addr;
               we_d    = 1'b0;
               wdata_d = 32'd0;
               cnt_d   = C_CNT_INIT;
            end
         end
         S_FETCH: begin
            if (branch_flush) discard_d = 1'b1;
            if (cnt_q == 4'd0) begin
               // A flushed fetch still finishes on the SRAM but is dropped here
               if (!fetch_dead) if_instr_d = sram_rdata;
               if_ready_d = ~fetch_dead;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DATA: begin
            if (cnt_q == 4'd0) begin
               if (!we_q) mem_rdata_d = sram_rdata;
               mem_ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            discard_d = 1'b0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      sram_en     = (state_q == S_FETCH) || (state_q == S_DATA);
      sram_we     = we_q & sram_en;
      sram_addr   = addr_q;
      sram_wdata  = wdata_q;
      if_instr    = if_instr_q;
      mem_rdata   = mem_rdata_q;
      if_ready    = if_ready_q;
      mem_ready   = mem_ready_q;
      freeze_if   = if_req & ~if_ready_q;
      freeze_pipe = data_req & ~mem_ready_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed table-driven bench for mem_port_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, branch_flush, mem_rd_en, mem_wr_en;
   logic [31:0] if_addr, mem_addr, mem_wdata;

   logic [31:0] if_instr0, mem_rdata0, sram_addr0, sram_wdata0, sram_rdata0;
   logic        if_ready0, mem_ready0, freeze_if0, freeze_pipe0, sram_en0, sram_we0;
   logic [31:0] if_instr1, mem_rdata1, sram_addr1, sram_wdata1, sram_rdata1;
   logic        if_ready1, mem_ready1, freeze_if1, freeze_pipe1, sram_en1, sram_we1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] sram_word(input logic [31:0] a);
      case (a)
         32'h10:  return 32'hE3A01005;
         32'h400: return 32'h12345678;
         32'h80:  return 32'hE59F1000;
         default: return a ^ 32'hA5A5A5A5;
      endcase
   endfunction

   // SRAM model: data only valid in the last access cycle, junk otherwise
   logic [3:0] en_cnt;
   always @(posedge clk) en_cnt <= sram_en0 ? en_cnt + 4'd1 : 4'd0;
   assign sram_rdata0 = (sram_en0 && en_cnt == 4'd3) ? sram_word(sram_addr0) : 32'hBAD0BAD0;
   assign sram_rdata1 = sram_en1 ? sram_word(sram_addr1) : 32'hBAD0BAD0;

   mem_port_arbiter #(.MEM_LAT(4)) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
      .branch_flush(branch_flush), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .if_instr(if_instr0), .if_ready(if_ready0), .mem_rdata(mem_rdata0),
      .mem_ready(mem_ready0), .freeze_if(freeze_if0), .freeze_pipe(freeze_pipe0),
      .sram_en(sram_en0), .sram_we(sram_we0), .sram_addr(sram_addr0),
      .sram_wdata(sram_wdata0), .sram_rdata(sram_rdata0)
   );

   mem_port_arbiter #(.MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
      .branch_flush(branch_flush), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .if_instr(if_instr1), .if_ready(if_ready1), .mem_rdata(mem_rdata1),
      .mem_ready(mem_ready1), .freeze_if(freeze_if1), .freeze_pipe(freeze_pipe1),
      .sram_en(sram_en1), .sram_we(sram_we1), .sram_addr(sram_addr1),
      .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata1)
   );

   typedef struct {
      logic        if_req;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      if_req = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0; branch_flush = 1'b0;
   endtask

   // Called in the first access cycle; returns in the DONE cycle
   task automatic access_cycles(input logic [31:0] a, input logic we, input logic [31:0] wd);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("acc%0d sram_en", i), 32'(sram_en0), 32'd1);
         chk($sformatf("acc%0d sram_addr", i), sram_addr0, a);
         chk($sformatf("acc%0d sram_we", i), 32'(sram_we0), 32'(we));
         if (we) chk($sformatf("acc%0d sram_wdata", i), sram_wdata0, wd);
         chk($sformatf("acc%0d readies", i), {30'd0, if_ready0, mem_ready0}, 32'd0);
         chk($sformatf("acc%0d freeze_if", i), 32'(freeze_if0), 32'(if_req));
         chk($sformatf("acc%0d freeze_pipe", i), 32'(freeze_pipe0), 32'(mem_rd_en | mem_wr_en));
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{if_req: 1'b1, rd: 1'b0, wr: 1'b0, addr: 32'h10,  wdata: 32'h0,        exp_rdata: 32'hE3A01005};
      tbl[1] = '{if_req: 1'b0, rd: 1'b1, wr: 1'b0, addr: 32'h400, wdata: 32'h0,        exp_rdata: 32'h12345678};
      tbl[2] = '{if_req: 1'b0, rd: 1'b0, wr: 1'b1, addr: 32'h404, wdata: 32'hDEADBEEF, exp_rdata: 32'h12345678};
      tbl[3] = '{if_req: 1'b1, rd: 1'b0, wr: 1'b0, addr: 32'h20,  wdata: 32'h0,        exp_rdata: 32'hA5A5A585};

      rst = 1'b1; idle_inputs();
      if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
      step(); step();
      chk("rst sram_en", 32'(sram_en0), 32'd0);
      chk("rst sram_we", 32'(sram_we0), 32'd0);
      chk("rst sram_addr", sram_addr0, 32'd0);
      chk("rst sram_wdata", sram_wdata0, 32'd0);
      chk("rst readies", {30'd0, if_ready0, mem_ready0}, 32'd0);
      chk("rst if_instr", if_instr0, 32'd0);
      chk("rst mem_rdata", mem_rdata0, 32'd0);
      rst = 1'b0;
      step();

      // Table-driven single accesses; each iteration starts in IDLE
      for (int v = 0; v < 4; v++) begin
         if_req = tbl[v].if_req; mem_rd_en = tbl[v].rd; mem_wr_en = tbl[v].wr;
         if_addr = tbl[v].addr; mem_addr = tbl[v].addr; mem_wdata = tbl[v].wdata;
         #1;
         chk($sformatf("v%0d freeze_if req", v), 32'(freeze_if0), 32'(tbl[v].if_req));
         chk($sformatf("v%0d freeze_pipe req", v), 32'(freeze_pipe0), 32'(tbl[v].rd | tbl[v].wr));
         step();
         access_cycles(tbl[v].addr, tbl[v].wr, tbl[v].wdata);
         chk($sformatf("v%0d sram_en done", v), 32'(sram_en0), 32'd0);
         if (tbl[v].rd | tbl[v].wr) begin
            chk($sformatf("v%0d mem_ready", v), 32'(mem_ready0), 32'd1);
            chk($sformatf("v%0d if_ready", v), 32'(if_ready0), 32'd0);
            chk($sformatf("v%0d mem_rdata", v), mem_rdata0, tbl[v].exp_rdata);
            chk($sformatf("v%0d freeze_pipe done", v), 32'(freeze_pipe0), 32'd0);
         end else begin
            chk($sformatf("v%0d if_ready", v), 32'(if_ready0), 32'd1);
            chk($sformatf("v%0d mem_ready", v), 32'(mem_ready0), 32'd0);
            chk($sformatf("v%0d if_instr", v), if_instr0, tbl[v].exp_rdata);
            chk($sformatf("v%0d freeze_if done", v), 32'(freeze_if0), 32'd0);
         end
         idle_inputs();
         step();
         chk($sformatf("v%0d idle sram_en", v), 32'(sram_en0), 32'd0);
         chk($sformatf("v%0d idle readies", v), {30'd0, if_ready0, mem_ready0}, 32'd0);
      end

      // Data beats fetch when both arrive in IDLE; fetch starts 2 cycles after mem_ready
      mem_rd_en = 1'b1; mem_addr = 32'h400; if_req = 1'b1; if_addr = 32'h10;
      step();
      access_cycles(32'h400, 1'b0, 32'h0);
      chk("prio mem_ready", 32'(mem_ready0), 32'd1);
      chk("prio if_ready", 32'(if_ready0), 32'd0);
      chk("prio mem_rdata", mem_rdata0, 32'h12345678);
      chk("prio freeze_if", 32'(freeze_if0), 32'd1);
      mem_rd_en = 1'b0;
      step();
      chk("prio idle sram_en", 32'(sram_en0), 32'd0);
      step();
      access_cycles(32'h10, 1'b0, 32'h0);
      chk("prio if_ready", 32'(if_ready0), 32'd1);
      chk("prio if_instr", if_instr0, 32'hE3A01005);
      idle_inputs();
      step();

      // Branch flush in the 2nd FETCH cycle drops that fetch
      if_req = 1'b1; if_addr = 32'h40;
      step();
      step();
      branch_flush = 1'b1;
      step();
      branch_flush = 1'b0; if_addr = 32'h80;
      #1;
      chk("flush addr held", sram_addr0, 32'h40);
      step(); step();
      chk("flush if_ready", 32'(if_ready0), 32'd0);
      chk("flush sram_en done", 32'(sram_en0), 32'd0);
      chk("flush freeze_if", 32'(freeze_if0), 32'd1);
      step();
      chk("flush idle sram_en", 32'(sram_en0), 32'd0);
      step();
      access_cycles(32'h80, 1'b0, 32'h0);
      chk("refetch if_ready", 32'(if_ready0), 32'd1);
      chk("refetch if_instr", if_instr0, 32'hE59F1000);
      idle_inputs();
      step();

      // Load raised in the 3rd fetch cycle waits for the fetch
      if_req = 1'b1; if_addr = 32'h10;
      step(); step(); step();
      mem_rd_en = 1'b1; mem_addr = 32'h408;
      #1;
      chk("mid freeze_pipe", 32'(freeze_pipe0), 32'd1);
      chk("mid addr still fetch", sram_addr0, 32'h10);
      step(); step();
      chk("mid if_ready", 32'(if_ready0), 32'd1);
      chk("mid if_instr", if_instr0, 32'hE3A01005);
      chk("mid mem_ready", 32'(mem_ready0), 32'd0);
      chk("mid freeze_pipe done", 32'(freeze_pipe0), 32'd1);
      if_req = 1'b0;
      step();
      chk("mid idle sram_en", 32'(sram_en0), 32'd0);
      chk("mid idle freeze_pipe", 32'(freeze_pipe0), 32'd1);
      step();
      access_cycles(32'h408, 1'b0, 32'h0);
      chk("mid mem_ready", 32'(mem_ready0), 32'd1);
      chk("mid mem_rdata", mem_rdata0, 32'hA5A5A1AD);
      chk("mid freeze_pipe end", 32'(freeze_pipe0), 32'd0);
      idle_inputs();
      step();

      // Reset in the 2nd DATA cycle aborts the access
      mem_rd_en = 1'b1; mem_addr = 32'h400;
      step();
      step();
      rst = 1'b1; mem_rd_en = 1'b0;
      step();
      chk("abort sram_en", 32'(sram_en0), 32'd0);
      chk("abort mem_ready", 32'(mem_ready0), 32'd0);
      chk("abort mem_rdata", mem_rdata0, 32'd0);
      rst = 1'b0;
      step();
      chk("abort idle sram_en", 32'(sram_en0), 32'd0);
      step(); step(); step(); step();
      chk("abort no pulse", {30'd0, if_ready0, mem_ready0}, 32'd0);

      // MEM_LAT=1: single access cycle, ready in cycle t+2
      mem_rd_en = 1'b1; mem_addr = 32'h400;
      step();
      chk("lat1 sram_en", 32'(sram_en1), 32'd1);
      chk("lat1 sram_addr", sram_addr1, 32'h400);
      chk("lat1 early ready", 32'(mem_ready1), 32'd0);
      step();
      chk("lat1 mem_ready", 32'(mem_ready1), 32'd1);
      chk("lat1 mem_rdata", mem_rdata1, 32'h12345678);
      chk("lat1 sram_en done", 32'(sram_en1), 32'd0);
      mem_rd_en = 1'b0;
      step();
      chk("lat1 ready drop", 32'(mem_ready1), 32'd0);
      for (int i = 0; i < 8; i++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
